// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package fetch_queue_pkg;
   localparam int WORD_LEN  = 32;
   localparam int ADDR_SIZE = 32;
   localparam int IFQ_DEPTH = 4;

   localparam logic [WORD_LEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [WORD_LEN-1:0]  instr;
      logic [ADDR_SIZE-1:0] pc;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue_instr_fields.sv
// Raw immediate bit-field slicing of an instruction word.
// Bits [6:0] hold the opcode and feed no immediate, so only [31:7] is taken.
module instr_fields (
   input  logic [31:7] instr,
   output logic [11:0] iimm,
   output logic [11:0] simm,
   output logic [11:0] bimm,
   output logic [19:0] uimm,
   output logic [19:0] jimm
);
   assign iimm = instr[31:20];
   assign simm = {instr[31:25], instr[11:7]};
   assign bimm = {instr[31], instr[7], instr[30:25], instr[11:8]};
   assign uimm = instr[31:12];
   assign jimm = {instr[31], instr[19:12], instr[20], instr[30:21]};
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO with valid/ready on both sides and flush on redirect.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WORD_LEN-1:0]        in_instr,
   input  logic [ADDR_SIZE-1:0]       in_pc,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORD_LEN-1:0]        out_instr,
   output logic [ADDR_SIZE-1:0]       out_pc,
   output logic [11:0]                iimm,
   output logic [11:0]                simm,
   output logic [11:0]                bimm,
   output logic [19:0]                uimm,
   output logic [19:0]                jimm,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fq_entry_t      mem [DEPTH];
   logic [PW-1:0]  wptr, rptr;
   logic           push, pop;

   // Both handshakes depend on registered occupancy only.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is never reset or cleared; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= '{instr: in_instr, pc: in_pc};
   end

   assign out_instr = out_valid ? mem[rptr].instr : NOP_INSTR;
   assign out_pc    = out_valid ? mem[rptr].pc    : '0;

   instr_fields u_fields (
      .instr (out_instr[31:7]),
      .iimm  (iimm),
      .simm  (simm),
      .bimm  (bimm),
      .uimm  (uimm),
      .jimm  (jimm)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_instr, out_pc;
   logic [11:0] iimm, simm, bimm;
   logic [19:0] uimm, jimm;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   fetch_queue #(.DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .iimm(iimm), .simm(simm), .bimm(bimm), .uimm(uimm), .jimm(jimm),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      #3;
      chk("rst_in_ready",  64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'h13);
      chk("rst_out_pc",    64'(out_pc), 64'd0);
      chk("rst_count",     64'(count), 64'd0);
      chk("rst_imms",      64'({iimm, simm, bimm, uimm, jimm} == '0), 64'd1);
      step();
      rstn = 1'b1;
      step();
      chk("idle_count", 64'(count), 64'd0);

      // single push, head visible next cycle
      push_one(32'hFFC1_0093, 32'h100);
      chk("p1_valid", 64'(out_valid), 64'd1);
      chk("p1_pc",    64'(out_pc), 64'h100);
      chk("p1_iimm",  64'(iimm), 64'hFFC);
      chk("p1_simm",  64'(simm), 64'hFE1);
      chk("p1_count", 64'(count), 64'd1);

      // fill to full
      push_one(32'h0000_1104, 32'h104);
      push_one(32'h0000_1108, 32'h108);
      push_one(32'h0000_110C, 32'h10C);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(in_ready), 64'd0);
      push_one(32'h0000_1200, 32'h200);
      chk("full_reject_count", 64'(count), 64'd4);
      chk("full_head_pc", 64'(out_pc), 64'h100);

      // pop one frees a slot next cycle
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pop_ready", 64'(in_ready), 64'd1);
      chk("pop_count", 64'(count), 64'd3);
      push_one(32'h0000_1110, 32'h110);
      chk("wrap_count", 64'(count), 64'd4);

      // drain across the pointer wrap
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", 64'(out_pc), 64'(32'h104 + 4 * i));
         step();
      end
      out_ready = 1'b0;
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);

      // streaming, one pop per cycle after the first
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_pc = 32'(4 * i); in_instr = 32'(i);
         if (i > 0) begin
            chk("stream_pc",    64'(out_pc), 64'(4 * (i - 1)));
            chk("stream_count", 64'(count), 64'd1);
         end
         step();
      end
      in_valid = 1'b0;
      chk("stream_last_pc", 64'(out_pc), 64'd36);
      step();
      out_ready = 1'b0;
      chk("stream_end_count", 64'(count), 64'd0);

      // flush beats same-cycle push and pop
      push_one(32'h0000_3300, 32'h300);
      push_one(32'h0000_3304, 32'h304);
      push_one(32'h0000_3308, 32'h308);
      chk("pre_flush_count", 64'(count), 64'd3);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_4400; in_pc = 32'h400; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      chk("flush_instr", 64'(out_instr), 64'h13);
      push_one(32'h0000_5500, 32'h500);
      chk("post_flush_count", 64'(count), 64'd1);
      chk("post_flush_pc",    64'(out_pc), 64'h500);

      // immediate field slicing
      flush = 1'b1; step(); flush = 1'b0;
      push_one(32'h0080_00EF, 32'h600);
      chk("jal_jimm", 64'(jimm), 64'h00004);
      chk("jal_uimm", 64'(uimm), 64'h00800);
      flush = 1'b1; step(); flush = 1'b0;
      push_one(32'hFE00_0EE3, 32'h700);
      chk("beq_bimm", 64'(bimm), 64'hFFE);
      chk("beq_simm", 64'(simm), 64'hFFD);

      // asynchronous reset away from any clock edge
      push_one(32'h0000_0001, 32'h800);
      chk("pre_arst_count", 64'(count), 64'd2);
      #2 rstn = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_pc",    64'(out_pc), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
